// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 4-bit LED bank between NREQ requesters, with an idle rotating pattern.
// Latency: req -> gnt/led one edge; no backpressure, requesters hold req high. Macro: LED_SHARE_FIXPRIO_EN.
// Backpressure: none; a grant is held HOLD_TICKS ticks or until its req drops, then one GAP cycle.
module led_share_arbiter #(
  parameter int CLK_FRE    = 50,
  parameter int TICK_MS    = 1000,
  parameter int HOLD_TICKS = 3,
  parameter int NREQ       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   pat,
  output logic [NREQ-1:0]     gnt,
  output logic [3:0]          led,
  output logic                tick
);

  localparam logic [31:0] TICK_CYC = 32'(CLK_FRE * 1000 * TICK_MS);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [31:0]   tick_cnt;
  logic [3:0]    idle_pat;
  logic [3:0]    idle_nxt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [HW-1:0] hold_cnt;

  logic          any_req;
  logic [PW-1:0] pick;
  logic [3:0]    pick_pat;
  logic [3:0]    win_pat;
  logic          win_req;
  logic [PW-1:0] win_inc;

  // Free-running prescaler; tick is a decode of the count so it lines up with tick_cnt==TICK_CYC-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_CYC - 32'd1) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  assign tick     = (tick_cnt == TICK_CYC - 32'd1);
  assign idle_nxt = tick ? {idle_pat[2:0], idle_pat[3]} : idle_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_pat <= 4'b0001;
    end else begin
      idle_pat <= idle_nxt;
    end
  end

  // Search starts at rr_ptr; with fixed priority rr_ptr never leaves 0, giving lowest-index-wins.
  always_comb begin
    int idx;
    logic [PW-1:0] cand;
    logic found;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    any_req = found;
  end

  always_comb begin
    pick_pat = 4'b0000;
    win_pat  = 4'b0000;
    win_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == pick) begin
        pick_pat = pat[4*i +: 4];
      end
      if (PW'(i) == win) begin
        win_pat = pat[4*i +: 4];
        win_req = req[i];
      end
    end
  end

  assign win_inc = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      led      <= 4'b0001;
      rr_ptr   <= '0;
      win      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win      <= pick;
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            led      <= pick_pat;
            hold_cnt <= '0;
            state    <= GRANT;
          end else begin
            led <= idle_nxt;
          end
        end
        GRANT: begin
          if ((tick && hold_cnt == HOLD_LAST) || !win_req) begin
            gnt   <= '0;
            led   <= idle_nxt;
            state <= GAP;
`ifdef LED_SHARE_FIXPRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= win_inc;
`endif
          end else begin
            led <= win_pat;
            if (tick) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        GAP: begin
          gnt   <= '0;
          led   <= idle_nxt;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          led   <= idle_nxt;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with a 1000-cycle tick, HOLD_TICKS=3, NREQ=3.
module tb_led_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] pat;
  logic [2:0]  gnt;
  logic [3:0]  led;
  logic        tick;

  int cyc;
  int passed;
  int total;
  int ntick;
  int base;

  led_share_arbiter #(
    .CLK_FRE(1), .TICK_MS(1), .HOLD_TICKS(3), .NREQ(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pat(pat),
    .gnt(gnt), .led(led), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; matches the prescaler count modulo 1000.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
  endtask

  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != c) begin
      total = total + 1;
      $error("FAIL goto: observed cycle %0d expected %0d", cyc, c);
    end
  endtask

  function automatic logic [3:0] idle_at(input int c);
    return 4'b0001 << ((c / 1000) % 4);
  endfunction

  initial begin
    passed = 0; total = 0; ntick = 0; base = 0;
    rst_n = 1'b0; req = 3'b000; pat = {4'hF, 4'h5, 4'hA};
    #12;
    chk("rst_led", 32'(led), 32'h1);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle rotation and prescaler
    for (int n = 1; n <= 4500; n++) begin
      @(posedge clk); #1;
      if (tick) ntick++;
      if ((n % 1000) >= 998 || (n % 1000) == 0) begin
        chk("idle_tick", 32'(tick), ((n % 1000) == 999) ? 32'h1 : 32'h0);
        chk("idle_led", 32'(led), 32'(idle_at(n)));
        chk("idle_gnt", 32'(gnt), 32'h0);
      end
    end
    chk("tick_count", 32'(ntick), 32'd4);

    // Single requester: grant, pass-through, release after 3 counted ticks, GAP, re-grant
    req = 3'b001;
    goto(4501);
    chk("g0_gnt", 32'(gnt), 32'h1);
    chk("g0_led", 32'(led), 32'hA);
    goto(4600);
    pat[3:0] = 4'h3;
    goto(4601);
    chk("g0_pass", 32'(led), 32'h3);
    pat[3:0] = 4'hA;
    goto(6999);
    chk("g0_hold", 32'(gnt), 32'h1);
    goto(7000);
    chk("g0_rel_gnt", 32'(gnt), 32'h0);
    chk("g0_rel_led", 32'(led), 32'h8);
    goto(7001);
    chk("g0_gap_gnt", 32'(gnt), 32'h0);
    goto(7002);
    chk("g0_regrant", 32'(gnt), 32'h1);
    chk("g0_regrant_led", 32'(led), 32'hA);

    // Asynchronous reset mid-grant
    goto(7010);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_led", 32'(led), 32'h1);
    chk("arst_tick", 32'(tick), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef LED_SHARE_FIXPRIO_EN
    req = 3'b110;
    rst_n = 1'b1;
    goto(1);
    chk("fp_first", 32'(gnt), 32'h2);
    chk("fp_first_led", 32'(led), 32'h5);
    goto(500);
    req = 3'b111;
    goto(999);
    chk("fp_tick_restart", 32'(tick), 32'h1);
    goto(2999);
    chk("fp_no_preempt", 32'(gnt), 32'h2);
    goto(3000);
    chk("fp_rel", 32'(gnt), 32'h0);
    goto(3002);
    chk("fp_next", 32'(gnt), 32'h1);
    chk("fp_next_led", 32'(led), 32'hA);
    base = 3002;
`else
    req = 3'b111;
    rst_n = 1'b1;
    goto(1);
    chk("rr_g0", 32'(gnt), 32'h1);
    chk("rr_g0_led", 32'(led), 32'hA);
    goto(999);
    chk("rr_tick_restart", 32'(tick), 32'h1);
    goto(2999);
    chk("rr_g0_hold", 32'(gnt), 32'h1);
    goto(3000);
    chk("rr_rel0", 32'(gnt), 32'h0);
    chk("rr_rel0_led", 32'(led), 32'h8);
    goto(3002);
    chk("rr_g1", 32'(gnt), 32'h2);
    chk("rr_g1_led", 32'(led), 32'h5);
    goto(6000);
    chk("rr_rel1", 32'(gnt), 32'h0);
    chk("rr_rel1_led", 32'(led), 32'h4);
    goto(6002);
    chk("rr_g2", 32'(gnt), 32'h4);
    chk("rr_g2_led", 32'(led), 32'hF);
    goto(9000);
    chk("rr_rel2", 32'(gnt), 32'h0);
    goto(9002);
    chk("rr_g3", 32'(gnt), 32'h1);
    chk("rr_g3_led", 32'(led), 32'hA);
    base = 9002;
`endif

    // Requester 0 drops 10 cycles into its grant
    goto(base + 10);
    req = 3'b010;
    goto(base + 11);
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_led", 32'(led), 32'(idle_at(base + 11)));
    req = 3'b011;
    goto(base + 12);
    chk("drop_gap", 32'(gnt), 32'h0);
    goto(base + 13);
`ifdef LED_SHARE_FIXPRIO_EN
    chk("drop_next", 32'(gnt), 32'h1);
    chk("drop_next_led", 32'(led), 32'hA);
`else
    chk("drop_next", 32'(gnt), 32'h2);
    chk("drop_next_led", 32'(led), 32'h5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
